// File: rtl/alarm_seq_ctrl_pkg.sv
// Shared types for the alarm sequencer: FSM states and keypad codes.
package alarm_pkg;
  typedef enum logic [2:0] {DISARMED, EXIT_WAIT, ARMED, ENTRY_WAIT, ALARM} state_e;

  localparam logic [3:0] KEY_NONE  = 4'h0;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  function automatic logic is_digit(input logic [3:0] k);
    return (k >= 4'd1) && (k <= 4'd9);
  endfunction
endpackage

// File: rtl/alarm_seq_ctrl_pin_entry.sv
// Keypad edge detect, 4-digit entry buffer and PIN comparator.
module pin_entry
  import alarm_pkg::*;
#(
  parameter logic [15:0] PIN = 16'h1234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad_i,
  input  logic       lock_i,
  output logic       pin_ok_o,
  output logic       pin_bad_o
);
  logic [3:0]  key_q;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        inv_q, inv_d;
  logic        ok_d, bad_d;
  logic        key_evt;

  assign key_evt = (keypad_i != KEY_NONE) && (key_q == KEY_NONE);

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    inv_d = inv_q;
    ok_d  = 1'b0;
    bad_d = 1'b0;
    if (lock_i) begin
      buf_d = '0;
      cnt_d = '0;
      inv_d = 1'b0;
    end else if (key_evt) begin
      if (is_digit(keypad_i)) begin
        buf_d = {buf_q[11:0], keypad_i};
        if (cnt_q == 3'd4) inv_d = 1'b1;
        else               cnt_d = cnt_q + 3'd1;
      end else if (keypad_i == KEY_ENTER) begin
        ok_d  = (cnt_q == 3'd4) && !inv_q && (buf_q == PIN);
        bad_d = !ok_d;
        buf_d = '0;
        cnt_d = '0;
        inv_d = 1'b0;
      end else if (keypad_i == KEY_CLEAR) begin
        buf_d = '0;
        cnt_d = '0;
        inv_d = 1'b0;
      end
    end
  end

  // key_q resets nonzero so a key held through reset is not taken as a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q     <= 4'hF;
      buf_q     <= '0;
      cnt_q     <= '0;
      inv_q     <= 1'b0;
      pin_ok_o  <= 1'b0;
      pin_bad_o <= 1'b0;
    end else begin
      key_q     <= keypad_i;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      inv_q     <= inv_d;
      pin_ok_o  <= ok_d;
      pin_bad_o <= bad_d;
    end
  end
endmodule

// File: rtl/alarm_seq_ctrl.sv
// Alarm sequencer: exit/entry delays, siren timeout and wrong-PIN lockout.
module alarm_seq_ctrl
  import alarm_pkg::*;
#(
  parameter int          EXIT_DLY  = 20,
  parameter int          ENTRY_DLY = 10,
  parameter int          SIREN_TO  = 60,
  parameter int          LOCK_TO   = 30,
  parameter logic [15:0] PIN       = 16'h1234,
  parameter int          MAX_FAIL  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic       front_door,
  input  logic       rear_door,
  input  logic       window,
  input  logic [3:0] keypad,
  output logic       alarm_siren,
  output logic       is_armed,
  output logic       is_wait_delay,
  output logic       code_error,
  output logic       lockout
);
  localparam int M1   = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
  localparam int M2   = (SIREN_TO > LOCK_TO) ? SIREN_TO : LOCK_TO;
  localparam int MAXD = (M1 > M2) ? M1 : M2;
  localparam int TW   = $clog2(MAXD) + 1;
  localparam int FW   = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] EXIT_T  = TW'(EXIT_DLY);
  localparam logic [TW-1:0] ENTRY_T = TW'(ENTRY_DLY);
  localparam logic [TW-1:0] SIREN_T = TW'(SIREN_TO);
  localparam logic [TW-1:0] LOCK_T  = TW'(LOCK_TO);
  localparam logic [TW-1:0] ONE     = TW'(1);

  state_e        state_q;
  logic [TW-1:0] tmr_q, lock_tmr_q;
  logic [FW-1:0] fail_q;
  logic          pin_ok, pin_bad, lock_hit;

  pin_entry #(.PIN(PIN)) u_pin (
    .clk      (clk),
    .reset    (reset),
    .keypad_i (keypad),
    .lock_i   (lockout),
    .pin_ok_o (pin_ok),
    .pin_bad_o(pin_bad)
  );

  assign lock_hit = pin_bad && ((int'(fail_q) + 1) >= MAX_FAIL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= DISARMED;
      tmr_q         <= '0;
      lock_tmr_q    <= '0;
      fail_q        <= '0;
      alarm_siren   <= 1'b0;
      is_armed      <= 1'b0;
      is_wait_delay <= 1'b0;
      code_error    <= 1'b0;
      lockout       <= 1'b0;
    end else begin
      alarm_siren   <= (state_q == ALARM);
      is_armed      <= (state_q == ARMED) || (state_q == ENTRY_WAIT) || (state_q == ALARM);
      is_wait_delay <= (state_q == EXIT_WAIT) || (state_q == ENTRY_WAIT);
      code_error    <= pin_bad;

      if (lock_hit) begin
        fail_q     <= fail_q + FW'(1);
        lockout    <= 1'b1;
        lock_tmr_q <= LOCK_T;
      end else if (pin_bad) begin
        fail_q <= fail_q + FW'(1);
      end else if (pin_ok) begin
        fail_q <= '0;
      end else if (lockout && ENA) begin
        if (lock_tmr_q <= ONE) begin
          lockout    <= 1'b0;
          lock_tmr_q <= '0;
          fail_q     <= '0;
        end else begin
          lock_tmr_q <= lock_tmr_q - ONE;
        end
      end

      // pin_ok is checked first everywhere so it beats expiry and sensors
      case (state_q)
        DISARMED: if (pin_ok) begin state_q <= EXIT_WAIT; tmr_q <= EXIT_T; end
        EXIT_WAIT: begin
          if (pin_ok) begin state_q <= DISARMED; tmr_q <= '0; end
          else if (ENA) begin
            if (tmr_q <= ONE) begin state_q <= ARMED; tmr_q <= '0; end
            else tmr_q <= tmr_q - ONE;
          end
        end
        ARMED: begin
          if (pin_ok) begin state_q <= DISARMED; tmr_q <= '0; end
          else if (window || lock_hit) begin state_q <= ALARM; tmr_q <= SIREN_T; end
          else if (front_door || rear_door) begin state_q <= ENTRY_WAIT; tmr_q <= ENTRY_T; end
        end
        ENTRY_WAIT: begin
          if (pin_ok) begin state_q <= DISARMED; tmr_q <= '0; end
          else if (window || lock_hit) begin state_q <= ALARM; tmr_q <= SIREN_T; end
          else if (ENA) begin
            if (tmr_q <= ONE) begin state_q <= ALARM; tmr_q <= SIREN_T; end
            else tmr_q <= tmr_q - ONE;
          end
        end
        ALARM: begin
          if (pin_ok) begin state_q <= DISARMED; tmr_q <= '0; end
          else if (ENA) begin
            if (tmr_q <= ONE) begin state_q <= ARMED; tmr_q <= '0; end
            else tmr_q <= tmr_q - ONE;
          end
        end
        default: begin state_q <= DISARMED; tmr_q <= '0; end
      endcase
    end
  end
endmodule
